// File: rtl/proc_cmd_sequencer.sv
// Host command sequencer for the MD5 string-match block: loads hash/length, streams a text batch, returns the result record.
// Registered outputs; text bytes forwarded one cycle after rx accept; rx stalls outside input states, tx holds until tx_ready.
module proc_cmd_sequencer #(
    parameter logic [15:0] DEFAULT_STR_LEN = 16'd152,
    parameter logic [15:0] MAX_STR_BITS    = 16'd440
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         proc_start,
    output logic [15:0]  proc_num_bytes,
    output logic [7:0]   proc_data,
    output logic         proc_data_valid,
    output logic         proc_match_char_next,
    output logic [127:0] proc_target_hash,
    output logic [15:0]  proc_str_len,
    input  logic         proc_done,
    input  logic         proc_match,
    input  logic [15:0]  proc_byte_pos,
    input  logic [7:0]   proc_match_char
);
    typedef enum logic [3:0] {
        IDLE, HASH, LEN, NUM_H, NUM_L, START, DATA, WAIT,
        TX_STAT, TX_POS_H, TX_POS_L, TX_CHAR, CHAR_GAP, TX_ACK, TX_ERR
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    cnt_q;
    logic [119:0]   shadow_q;
    logic [7:0]     hi_q;
    logic           match_q;
    logic [15:0]    pos_q;

    logic           rx_ready_q;
    logic           tx_valid_q;
    logic [7:0]     tx_data_q;
    logic           proc_start_q;
    logic [15:0]    proc_num_bytes_q;
    logic [7:0]     proc_data_q;
    logic           proc_data_valid_q;
    logic           proc_match_char_next_q;
    logic [127:0]   proc_target_hash_q;
    logic [15:0]    proc_str_len_q;

    logic           rx_fire;
    logic           tx_fire;
    logic [15:0]    rx_word;
    logic           len_ok;

    assign rx_fire = rx_valid & rx_ready_q;
    assign tx_fire = tx_valid_q & tx_ready;
    assign rx_word = {hi_q, rx_data};
    assign len_ok  = (rx_word != 16'd0) && (rx_word <= MAX_STR_BITS) && (rx_word[2:0] == 3'd0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rx_fire) begin
                    case (rx_data)
                        8'h01:   state_d = HASH;
                        8'h02:   state_d = LEN;
                        8'h03:   state_d = NUM_H;
                        default: state_d = TX_ERR;
                    endcase
                end
            end
            HASH:     if (rx_fire && cnt_q == 16'd1) state_d = TX_ACK;
            LEN:      if (rx_fire && cnt_q == 16'd1) state_d = len_ok ? TX_ACK : TX_ERR;
            NUM_H:    if (rx_fire) state_d = NUM_L;
            NUM_L:    if (rx_fire) state_d = START;
            START:    state_d = (cnt_q != 16'd0) ? DATA : WAIT;
            DATA:     if (rx_fire && cnt_q == 16'd1) state_d = WAIT;
            WAIT:     if (proc_done) state_d = TX_STAT;
            TX_STAT:  if (tx_fire) state_d = TX_POS_H;
            TX_POS_H: if (tx_fire) state_d = TX_POS_L;
            TX_POS_L: if (tx_fire) state_d = match_q ? TX_CHAR : IDLE;
            TX_CHAR:  if (tx_fire) state_d = (cnt_q == 16'd1) ? IDLE : CHAR_GAP;
            CHAR_GAP: state_d = TX_CHAR;
            TX_ACK:   if (tx_fire) state_d = IDLE;
            TX_ERR:   if (tx_fire) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q                <= IDLE;
            cnt_q                  <= 16'd0;
            shadow_q               <= '0;
            hi_q                   <= 8'd0;
            match_q                <= 1'b0;
            pos_q                  <= 16'd0;
            rx_ready_q             <= 1'b0;
            tx_valid_q             <= 1'b0;
            tx_data_q              <= 8'd0;
            proc_start_q           <= 1'b0;
            proc_num_bytes_q       <= 16'd0;
            proc_data_q            <= 8'd0;
            proc_data_valid_q      <= 1'b0;
            proc_match_char_next_q <= 1'b0;
            proc_target_hash_q     <= '0;
            proc_str_len_q         <= DEFAULT_STR_LEN;
        end else begin
            state_q                <= state_d;
            rx_ready_q             <= state_d inside {IDLE, HASH, LEN, NUM_H, NUM_L, DATA};
            proc_start_q           <= (state_d == START);
            proc_data_valid_q      <= 1'b0;
            proc_match_char_next_q <= 1'b0;
            if (tx_fire) tx_valid_q <= 1'b0;

            case (state_q)
                IDLE: if (rx_fire) cnt_q <= (rx_data == 8'h01) ? 16'd16 : 16'd2;
                HASH: begin
                    if (rx_fire) begin
                        shadow_q <= {shadow_q[111:0], rx_data};
                        cnt_q    <= cnt_q - 16'd1;
                        // the live target only changes once the whole hash has arrived
                        if (cnt_q == 16'd1) proc_target_hash_q <= {shadow_q, rx_data};
                    end
                end
                LEN: begin
                    if (rx_fire) begin
                        hi_q  <= rx_data;
                        cnt_q <= cnt_q - 16'd1;
                        if (cnt_q == 16'd1 && len_ok) proc_str_len_q <= rx_word;
                    end
                end
                NUM_H: if (rx_fire) hi_q <= rx_data;
                NUM_L: begin
                    if (rx_fire) begin
                        proc_num_bytes_q <= rx_word;
                        cnt_q            <= rx_word;
                    end
                end
                DATA: begin
                    if (rx_fire) begin
                        proc_data_q       <= rx_data;
                        proc_data_valid_q <= 1'b1;
                        cnt_q             <= cnt_q - 16'd1;
                    end
                end
                WAIT: begin
                    if (proc_done) begin
                        match_q <= proc_match;
                        pos_q   <= proc_byte_pos;
                        cnt_q   <= proc_str_len_q >> 3;
                    end
                end
                TX_CHAR: begin
                    // the char is captured a cycle into TX_CHAR so the previous shift has landed
                    if (!tx_valid_q) begin
                        tx_data_q  <= proc_match_char;
                        tx_valid_q <= 1'b1;
                    end else if (tx_ready) begin
                        proc_match_char_next_q <= 1'b1;
                        cnt_q                  <= cnt_q - 16'd1;
                    end
                end
                default: ;
            endcase

            if (state_d != state_q) begin
                case (state_d)
                    TX_STAT:  begin tx_valid_q <= 1'b1; tx_data_q <= {7'd0, proc_match}; end
                    TX_POS_H: begin tx_valid_q <= 1'b1; tx_data_q <= pos_q[15:8]; end
                    TX_POS_L: begin tx_valid_q <= 1'b1; tx_data_q <= pos_q[7:0]; end
                    TX_ACK:   begin tx_valid_q <= 1'b1; tx_data_q <= (state_q == HASH) ? 8'h01 : 8'h02; end
                    TX_ERR:   begin tx_valid_q <= 1'b1; tx_data_q <= 8'hEE; end
                    default: ;
                endcase
            end
        end
    end

    assign rx_ready             = rx_ready_q;
    assign tx_valid             = tx_valid_q;
    assign tx_data              = tx_data_q;
    assign proc_start           = proc_start_q;
    assign proc_num_bytes       = proc_num_bytes_q;
    assign proc_data            = proc_data_q;
    assign proc_data_valid      = proc_data_valid_q;
    assign proc_match_char_next = proc_match_char_next_q;
    assign proc_target_hash     = proc_target_hash_q;
    assign proc_str_len         = proc_str_len_q;
endmodule
